// File: rtl/canvas_pkg.sv
// Shared constants and types for the canvas memory access controller.
// The canvas is a 128x128 array of 3-bit color codes, linearly addressed as {y,x}.
package canvas_pkg;

    localparam int CANVAS_DIM = 128;
    localparam int COORD_W    = $clog2(CANVAS_DIM);
    localparam int ADR_W      = 2 * COORD_W;
    localparam int COLOR_W    = 3;
    localparam int BRUSH_W    = 8;
    localparam int DROP_W     = 8;

    localparam logic [COLOR_W-1:0] ERASE    = 3'd0;
    localparam logic [ADR_W-1:0]   LAST_ADR = {ADR_W{1'b1}};

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clear_state_t;

endpackage

// File: rtl/canvas_clear_seq.sv
// Full-canvas erase sequencer: walks every address once, advancing only on
// cycles where the memory port is granted to it.
module canvas_clear_seq
    import canvas_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clearReq,
    input  logic             grant,
    output logic             clearBusy,
    output logic             want,
    output logic [ADR_W-1:0] address
);

    clear_state_t     state, state_nxt;
    logic [ADR_W-1:0] count, count_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // A request arriving mid-sweep is ignored; the sweep never restarts.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            IDLE: begin
                if (clearReq) begin
                    state_nxt = CLEAR;
                    count_nxt = '0;
                end
            end
            CLEAR: begin
                if (grant) begin
                    count_nxt = count + 1'b1;
                    if (count == LAST_ADR) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        clearBusy = (state == CLEAR);
        want      = (state == CLEAR);
        address   = count;
    end

endmodule

// File: rtl/canvas_access_ctrl.sv
// Single-port canvas RAM arbiter: display reads take the port first, then the
// erase sweep, then one buffered brush write.
module canvas_access_ctrl
    import canvas_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               rdReq,
    input  logic [COORD_W-1:0] rdX,
    input  logic [COORD_W-1:0] rdY,
    output logic               rdValid,
    output logic [COLOR_W-1:0] rdColor,
    input  logic               brush,
    input  logic [BRUSH_W-1:0] wx,
    input  logic [BRUSH_W-1:0] wy,
    input  logic [COLOR_W-1:0] newColor,
    output logic               brushReady,
    input  logic               clearReq,
    output logic               clearBusy,
    output logic [ADR_W-1:0]   memAdr,
    output logic               memRe,
    output logic               memWe,
    output logic [COLOR_W-1:0] memWData,
    input  logic [COLOR_W-1:0] memRData,
    output logic [DROP_W-1:0]  dropCount
);

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == {DROP_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic               alive;
    logic               pending;
    logic [ADR_W-1:0]   brush_adr;
    logic [COLOR_W-1:0] brush_color;
    logic               vld_p1;
    logic               clr_busy, clr_want, clr_grant, brush_grant;
    logic [ADR_W-1:0]   clr_adr;
    logic               accept, out_of_range;

    canvas_clear_seq u_clear (
        .clk       (clk),
        .reset     (reset),
        .clearReq  (clearReq),
        .grant     (clr_grant),
        .clearBusy (clr_busy),
        .want      (clr_want),
        .address   (clr_adr)
    );

    // A brush that arrives with (or before) a clear request waits for the
    // whole sweep so it lands on the erased canvas.
    assign clr_grant    = clr_want & ~rdReq;
    assign brush_grant  = pending & ~rdReq & ~clr_busy & ~clearReq;
    assign brushReady   = alive & ~pending & ~clr_busy;
    assign clearBusy    = clr_busy;
    assign accept       = brush & brushReady;
    assign out_of_range = wx[BRUSH_W-1] | wy[BRUSH_W-1];

    // Port stage: registered strobes, address and write data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            memRe    <= 1'b0;
            memWe    <= 1'b0;
            memAdr   <= '0;
            memWData <= '0;
        end else begin
            memRe <= rdReq;
            memWe <= clr_grant | brush_grant;
            if (rdReq) begin
                memAdr <= {rdY, rdX};
            end else if (clr_grant) begin
                memAdr   <= clr_adr;
                memWData <= ERASE;
            end else if (brush_grant) begin
                memAdr   <= brush_adr;
                memWData <= brush_color;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alive       <= 1'b0;
            pending     <= 1'b0;
            brush_adr   <= '0;
            brush_color <= '0;
            dropCount   <= '0;
        end else begin
            alive <= 1'b1;
            if (accept && out_of_range) begin
                dropCount <= sat_inc(dropCount);
            end else if (accept) begin
                pending     <= 1'b1;
                brush_adr   <= {wy[COORD_W-1:0], wx[COORD_W-1:0]};
                brush_color <= newColor;
            end else if (brush_grant) begin
                pending <= 1'b0;
            end
        end
    end

    // Read return: p1 tracks the RAM access cycle, data captured one edge later
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1  <= 1'b0;
            rdValid <= 1'b0;
            rdColor <= '0;
        end else begin
            vld_p1  <= memRe;
            rdValid <= vld_p1;
            if (vld_p1) rdColor <= memRData;
        end
    end

endmodule
